// File: rtl/dense_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : dense_input_loader
// Purpose  : Collects a 64-beat stream of (activation, weight) pairs plus a
//            bias sampled on beat 0. It then presents the completed vectors
//            to a dense-layer consumer until that consumer acknowledges them.
// Ports    : clk, rst_n (async, active-low)
//            s_valid/s_ready/s_x/s_w/s_bias/s_last : beat input handshake
//            x_vec/w_vec/bias_out                   : presented vectors
//            vec_valid/vec_ack                      : presentation handshake
//            beat_cnt                               : next beat index
//            err                                    : sticky framing error
// Config   : DENSE_LOADER_DOUBLE_BUF_EN -- when defined, a back bank set is
//            loaded while the front set is presented. When undefined, a
//            single bank set is used and input stalls while presenting.
// Revision : 1.0 - initial release
// ============================================================================
module dense_input_loader (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [31:0] s_x,
    input  logic signed [31:0] s_w,
    input  logic signed [31:0] s_bias,
    input  logic               s_last,
    output logic signed [31:0] x_vec [0:63],
    output logic signed [31:0] w_vec [0:63],
    output logic signed [31:0] bias_out,
    output logic               vec_valid,
    input  logic               vec_ack,
    output logic [5:0]         beat_cnt,
    output logic               err
);

    localparam int DEPTH = 64;

    typedef enum logic [0:0] {
        ST_LOAD    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        accept;
    logic        last_beat;
    logic        complete;

    assign accept    = s_valid && s_ready;
    assign last_beat = (cnt_q == 6'd63);
    assign complete  = accept && last_beat;

    // Beat counter and framing error; identical in both builds.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept) begin
            if (last_beat) begin
                cnt_d = 6'd0;
                if (!s_last) begin
                    err_d = 1'b1;
                end
            end else if (s_last) begin
                // Early end-of-frame: abandon the partial vector.
                cnt_d = 6'd0;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= 6'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign vec_valid = (state_q == ST_PRESENT);
    assign beat_cnt  = cnt_q;
    assign err       = err_q;

`ifdef DENSE_LOADER_DOUBLE_BUF_EN
    logic signed [31:0] back_x_q  [DEPTH];
    logic signed [31:0] back_w_q  [DEPTH];
    logic signed [31:0] front_x_q [DEPTH];
    logic signed [31:0] front_w_q [DEPTH];
    logic signed [31:0] merged_x  [DEPTH];
    logic signed [31:0] merged_w  [DEPTH];
    logic signed [31:0] back_bias_q, front_bias_q;
    logic               back_full_q, back_full_d;
    logic               load_front;

    // The back bank combined with the beat being accepted this cycle.
    // This allows a vector to be promoted to the front in the same cycle that
    // its final beat lands, which keeps the beat-63-to-vec_valid latency at
    // one clock.
    always_comb begin
        merged_x = back_x_q;
        merged_w = back_w_q;
        if (accept) begin
            merged_x[cnt_q] = s_x;
            merged_w[cnt_q] = s_w;
        end
    end

    always_comb begin
        state_d     = state_q;
        back_full_d = back_full_q;
        load_front  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (complete) begin
                    state_d    = ST_PRESENT;
                    load_front = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (vec_ack) begin
                    if (back_full_q || complete) begin
                        load_front  = 1'b1;
                        back_full_d = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (complete) begin
                    back_full_d = 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            back_full_q  <= 1'b0;
            back_bias_q  <= '0;
            front_bias_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                back_x_q[i]  <= '0;
                back_w_q[i]  <= '0;
                front_x_q[i] <= '0;
                front_w_q[i] <= '0;
            end
        end else begin
            back_full_q <= back_full_d;
            if (accept) begin
                back_x_q[cnt_q] <= s_x;
                back_w_q[cnt_q] <= s_w;
                if (cnt_q == 6'd0) begin
                    back_bias_q <= s_bias;
                end
            end
            if (load_front) begin
                front_x_q    <= merged_x;
                front_w_q    <= merged_w;
                front_bias_q <= back_bias_q;
            end
        end
    end

    assign s_ready  = rst_n && !back_full_q;
    assign bias_out = front_bias_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_out
        assign x_vec[gi] = front_x_q[gi];
        assign w_vec[gi] = front_w_q[gi];
    end
`else
    logic signed [31:0] bank_x_q [DEPTH];
    logic signed [31:0] bank_w_q [DEPTH];
    logic signed [31:0] bias_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:    if (complete) state_d = ST_PRESENT;
            ST_PRESENT: if (vec_ack)  state_d = ST_LOAD;
            default:    state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_x_q[i] <= '0;
                bank_w_q[i] <= '0;
            end
        end else if (accept) begin
            bank_x_q[cnt_q] <= s_x;
            bank_w_q[cnt_q] <= s_w;
            if (cnt_q == 6'd0) begin
                bias_q <= s_bias;
            end
        end
    end

    // Input is held off while the single bank is being presented. The reset
    // term keeps s_ready low for the whole time reset is asserted.
    assign s_ready  = rst_n && (state_q == ST_LOAD);
    assign bias_out = bias_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_out
        assign x_vec[gi] = bank_x_q[gi];
        assign w_vec[gi] = bank_w_q[gi];
    end
`endif

endmodule
`default_nettype wire
